proc_control_unit: RTL and testbench

//   Control FSM for the 9-bit register-array datapath. Fetches a 9-bit instruction

---
 rtl/proc_control_unit.sv | 162 ++++++++++++++++
 tb/tb_proc_control_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/proc_control_unit.sv
// proc_control_unit
//   Control FSM for the 9-bit register-array datapath. It fetches an instruction
//   word III_XXX_YYY from DIN into IR. It then sequences mv, mvi, add and sub
//   over 2-4 cycles (T0..T3). It does this by driving one-hot bus selects,
//   register load enables and the AddSub control.
//
//   Build option: define CTRL_MVNZ_EN to enable opcode 100 = mvnz Rx,Ry, which
//   moves Ry into Rx only when G_nz=1. Without the macro, opcode 100 is a NOP
//   and G_nz is ignored.
//
// Ports
//   Clock          rising-edge clock
//   rst            asynchronous active-low reset (forces T0, IR = 0)
//   Run            start request, sampled only in T0
//   DIN[8:0]       instruction word in T0; immediate operand in T1 of mvi
//   G_nz           datapath G register is non-zero (mvnz only)
//   R0out..R7out   bus select: Rn drives Bus
//   Gout, DINout   bus select: G / DIN drives Bus
//   R0in..R7in     load enable: Rn <= Bus
//   Ain, Gin       load enable: A <= Bus, G <= A +/- Bus
//   AddSub         0 = add, 1 = subtract
//   Done           high during the final cycle of an instruction
module proc_control_unit #(
  parameter int DATA_W = 9
) (
  input  logic              Clock,
  input  logic              rst,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  input  logic              G_nz,
  output logic              R0out,
  output logic              R1out,
  output logic              R2out,
  output logic              R3out,
  output logic              R4out,
  output logic              R5out,
  output logic              R6out,
  output logic              R7out,
  output logic              Gout,
  output logic              DINout,
  output logic              R0in,
  output logic              R1in,
  output logic              R2in,
  output logic              R3in,
  output logic              R4in,
  output logic              R5in,
  output logic              R6in,
  output logic              R7in,
  output logic              Ain,
  output logic              Gin,
  output logic              AddSub,
  output logic              Done
);

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
`ifdef CTRL_MVNZ_EN
  localparam logic [2:0] OP_MVNZ = 3'b100;
`endif

  state_t            state, state_nxt;
  logic [DATA_W-1:0] ir;
  logic [2:0]        op, rx, ry;

  logic [7:0] r_out, r_in;
  logic       g_out, din_out, a_in, g_in, add_sub, done;

  assign op = ir[8:6];
  assign rx = ir[5:3];
  assign ry = ir[2:0];

`ifndef CTRL_MVNZ_EN
  logic unused_g_nz;
  assign unused_g_nz = G_nz;
`endif

  always_ff @(posedge Clock or negedge rst) begin
    if (!rst) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == T0 && Run)
        ir <= DIN;
    end
  end

  always_comb begin
    state_nxt = state;
    r_out     = '0;
    r_in      = '0;
    g_out     = 1'b0;
    din_out   = 1'b0;
    a_in      = 1'b0;
    g_in      = 1'b0;
    add_sub   = 1'b0;
    done      = 1'b0;
    case (state)
      T0: begin
        if (Run)
          state_nxt = T1;
      end
      T1: begin
        state_nxt = T0;
        case (op)
          OP_MV: begin
            r_out[ry] = 1'b1;
            r_in[rx]  = 1'b1;
            done      = 1'b1;
          end
          OP_MVI: begin
            din_out  = 1'b1;
            r_in[rx] = 1'b1;
            done     = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            r_out[rx] = 1'b1;
            a_in      = 1'b1;
            state_nxt = T2;
          end
`ifdef CTRL_MVNZ_EN
          OP_MVNZ: begin
            done = 1'b1;
            if (G_nz) begin
              r_out[ry] = 1'b1;
              r_in[rx]  = 1'b1;
            end
          end
`endif
          default: done = 1'b1;
        endcase
      end
      T2: begin
        r_out[ry] = 1'b1;
        g_in      = 1'b1;
        add_sub   = (op == OP_SUB);
        state_nxt = T3;
      end
      T3: begin
        g_out     = 1'b1;
        r_in[rx]  = 1'b1;
        done      = 1'b1;
        state_nxt = T0;
      end
      default: state_nxt = T0;
    endcase
  end

  assign {R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out} = r_out;
  assign {R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in}         = r_in;
  assign Gout   = g_out;
  assign DINout = din_out;
  assign Ain    = a_in;
  assign Gin    = g_in;
  assign AddSub = add_sub;
  assign Done   = done;

endmodule

// File: tb/tb_proc_control_unit.sv
// Testbench for proc_control_unit. A small datapath (R0..R7, A, G, Bus) is
// driven by the control outputs. An instruction-level register model gives
// the expected architectural results. Per-cycle control words are expected
// from the documented instruction sequences.
module tb_proc_control_unit;

  logic       Clock = 1'b0;
  logic       rst   = 1'b0;
  logic       Run   = 1'b0;
  logic [8:0] DIN   = '0;
  logic       G_nz;
  logic R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out;
  logic R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in;
  logic Gout, DINout, Ain, Gin, AddSub, Done;

  int vectors    = 0;
  int miscompares = 0;

  proc_control_unit #(.DATA_W(9)) dut (
    .Clock(Clock), .rst(rst), .Run(Run), .DIN(DIN), .G_nz(G_nz),
    .R0out(R0out), .R1out(R1out), .R2out(R2out), .R3out(R3out),
    .R4out(R4out), .R5out(R5out), .R6out(R6out), .R7out(R7out),
    .Gout(Gout), .DINout(DINout),
    .R0in(R0in), .R1in(R1in), .R2in(R2in), .R3in(R3in),
    .R4in(R4in), .R5in(R5in), .R6in(R6in), .R7in(R7in),
    .Ain(Ain), .Gin(Gin), .AddSub(AddSub), .Done(Done)
  );

  always #5 Clock = ~Clock;

  logic [7:0]  rout_v, rin_v;
  logic [21:0] ctrl;
  assign rout_v = {R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign rin_v  = {R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  assign ctrl   = {rout_v, Gout, DINout, rin_v, Ain, Gin, AddSub, Done};

  // Bench datapath, steered only by the DUT's control outputs.
  logic [8:0] dp_r [8] = '{default: '0};
  logic [8:0] dp_a = '0;
  logic [8:0] dp_g = '0;
  logic [8:0] bus;

  always_comb begin
    bus = '0;
    for (int i = 0; i < 8; i++)
      if (rout_v[i]) bus = bus | dp_r[i];
    if (Gout)   bus = bus | dp_g;
    if (DINout) bus = bus | DIN;
  end

  assign G_nz = (dp_g != '0);

  always @(posedge Clock) begin
    if (Ain) dp_a <= bus;
    if (Gin) dp_g <= AddSub ? dp_a - bus : dp_a + bus;
    for (int i = 0; i < 8; i++)
      if (rin_v[i]) dp_r[i] <= bus;
  end

  // Architectural model: register file and G after each completed instruction.
  logic [8:0] ar [8] = '{default: '0};
  logic [8:0] ag = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [21:0] mk(logic [7:0] ro, logic go, logic dio, logic [7:0] ri,
                                     logic ai, logic gi, logic as, logic dn);
    return {ro, go, dio, ri, ai, gi, as, dn};
  endfunction

  task automatic do_instr(input logic [8:0] ir, input logic [8:0] imm);
    logic [21:0] exp_q[$];
    logic [2:0]  op, x, y;
    logic [8:0]  res;
    logic [7:0]  bx, by;
    op = ir[8:6]; x = ir[5:3]; y = ir[2:0];
    bx = 8'd1 << x; by = 8'd1 << y;
    res = '0;
    case (op)
      3'd0: begin exp_q.push_back(mk(by, 0, 0, bx, 0, 0, 0, 1)); ar[x] = ar[y]; end
      3'd1: begin exp_q.push_back(mk('0, 0, 1, bx, 0, 0, 0, 1)); ar[x] = imm; end
      3'd2, 3'd3: begin
        res = (op == 3'd2) ? ar[x] + ar[y] : ar[x] - ar[y];
        exp_q.push_back(mk(bx, 0, 0, '0, 1, 0, 0, 0));
        exp_q.push_back(mk(by, 0, 0, '0, 0, 1, op == 3'd3, 0));
        exp_q.push_back(mk('0, 1, 0, bx, 0, 0, 0, 1));
        ar[x] = res;
        ag    = res;
      end
`ifdef CTRL_MVNZ_EN
      3'd4: begin
        if (ag != '0) begin
          exp_q.push_back(mk(by, 0, 0, bx, 0, 0, 0, 1));
          ar[x] = ar[y];
        end else
          exp_q.push_back(mk('0, 0, 0, '0, 0, 0, 0, 1));
      end
`endif
      default: exp_q.push_back(mk('0, 0, 0, '0, 0, 0, 0, 1));
    endcase

    @(negedge Clock);
    check("t0_idle", ctrl, '0);
    Run = 1'b1;
    DIN = ir;
    @(posedge Clock); #1;
    Run = 1'($urandom);
    DIN = imm;
    foreach (exp_q[k]) begin
      @(negedge Clock);
      check($sformatf("op%0d_x%0d_y%0d_c%0d", op, x, y, k + 1), ctrl, exp_q[k]);
      @(posedge Clock); #1;
    end
    check($sformatf("reg_r%0d_op%0d", x, op), dp_r[x], ar[x]);
    if (op == 3'd2 || op == 3'd3)
      check("reg_g", dp_g, ag);
  endtask

  task automatic idle();
    @(negedge Clock);
    Run = 1'b0;
    check("idle0", ctrl, '0);
    @(posedge Clock); #1;
    @(negedge Clock);
    check("idle1", ctrl, '0);
  endtask

  initial begin
    #1;
    check("rst_outputs", ctrl, '0);
    #11 rst = 1'b1;

    do_instr(9'b001_000_000, 9'h1A5);   // mvi R0,#1A5
    do_instr(9'b001_001_000, 9'h1F0);   // mvi R1,#1F0
    do_instr(9'b000_111_001, 9'h000);   // mv R7,R1
    do_instr(9'b001_000_000, 9'd5);
    do_instr(9'b001_001_000, 9'd3);
    do_instr(9'b010_000_001, 9'h000);   // add R0,R1 -> 8
    check("add_r0_8", dp_r[0], 9'd8);
    do_instr(9'b001_010_000, 9'd2);
    do_instr(9'b001_011_000, 9'd5);
    do_instr(9'b011_010_011, 9'h000);   // sub R2,R3 -> 1FD
    check("sub_wrap", dp_r[2], 9'h1FD);
    do_instr(9'b000_011_011, 9'h000);   // mv R3,R3
    do_instr(9'b010_010_010, 9'h000);   // add R2,R2
    do_instr(9'b111_000_000, 9'h1FF);   // illegal -> NOP
    do_instr(9'b001_100_000, 9'h011);
    do_instr(9'b001_101_000, 9'h022);
    do_instr(9'b011_110_110, 9'h000);   // sub R6,R6 -> G=0
    do_instr(9'b100_100_101, 9'h000);   // mvnz R4,R5 with G=0
    do_instr(9'b010_110_101, 9'h000);   // add R6,R5 -> G!=0
    do_instr(9'b100_100_101, 9'h000);   // mvnz R4,R5 with G!=0
    idle();

    // Abort an add in T2; no Done and no further loads.
    @(negedge Clock);
    Run = 1'b1;
    DIN = 9'b010_010_011;
    @(posedge Clock); #1;
    Run = 1'b0;
    @(negedge Clock);
    check("abort_t1", ctrl, mk(8'b0000_0100, 0, 0, '0, 1, 0, 0, 0));
    @(posedge Clock); #2;
    rst = 1'b0;
    #1;
    check("rst_async", ctrl, '0);
    @(posedge Clock); #1;
    check("rst_held", ctrl, '0);
    @(negedge Clock);
    rst = 1'b1;
    check("abort_r2", dp_r[2], ar[2]);
    check("abort_g", dp_g, ag);
    idle();

    for (int n = 0; n < 300; n++) begin
      do_instr(9'($urandom), 9'($urandom));
      if ($urandom_range(0, 7) == 0) idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
